ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl_pkg.sv | 20 ++
 rtl/ssd_hex_decode.sv | 11 +
 rtl/ssd_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared display definitions for the seven-segment scan controller:
// active-low segment encodings and the hex-to-segment lookup.
package ssd_scan_ctrl_pkg;

  // All segments off, active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 15 is the leftmost entry, so HEX_SEG_TABLE[n] is the pattern for nibble n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module ssd_hex_decode
  import ssd_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a shadowed display register
// that commits only at frame boundaries, paging and leading-zero blanking.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter  int DIGITS      = 4,
  parameter  int DATA_W      = 32,
  parameter  int REFRESH_DIV = 100000,
  localparam int PAGES       = DATA_W / (4 * DIGITS),
  localparam int PAGE_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic [PAGE_W-1:0] page,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              frame_sync
);

  localparam int WIN_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0]         pre_cnt;
  logic                     tick;
  logic [IDX_W-1:0]         idx;
  logic                     scan_en;
  logic [DATA_W-1:0]        shadow_data;
  logic [PAGE_W-1:0]        shadow_page;
  logic                     pending;
  logic [DATA_W-1:0]        disp_data;
  logic [PAGE_W-1:0]        disp_page;
  logic                     commit;
  logic [DATA_W-1:0]        page_data;
  logic [DIGITS-1:0][3:0]   window;
  logic [3:0]               nibble;
  logic [6:0]               dec_seg;
  logic [IDX_W-1:0]         top_nz;
  logic                     blanked;
  logic [DIGITS-1:0]        an_next;
  logic [6:0]               seg_next;

  assign tick   = (pre_cnt == PRE_LAST);
  assign commit = tick && (idx == LAST_IDX) && pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // idx parks on the last digit in reset so the first tick lands on digit 0;
  // scan_en holds the outputs blank until that first tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= LAST_IDX;
      scan_en <= 1'b0;
    end else if (tick) begin
      idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      scan_en <= 1'b1;
    end
  end

  // load is a bare capture strobe with no ready: every edge with load=1
  // overwrites the shadow, and the newest capture always wins the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_data <= '0;
      shadow_page <= '0;
      pending     <= 1'b0;
    end else begin
      if (load) begin
        shadow_data <= data_in;
        shadow_page <= page;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_data  <= '0;
      disp_page  <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= commit;
      if (commit) begin
        disp_data <= shadow_data;
        disp_page <= shadow_page;
      end
    end
  end

  // Out-of-range pages fall back to the least-significant window.
  always_comb begin
    page_data = disp_data;
    if (int'(disp_page) < PAGES) begin
      page_data = disp_data >> (int'(disp_page) * WIN_W);
    end
    window = page_data[WIN_W-1:0];
    nibble = window[idx];
  end

  ssd_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    top_nz = '0;
    for (int w = 0; w < DIGITS; w++) begin
      if (window[w] != 4'h0) begin
        top_nz = IDX_W'(w);
      end
    end
    blanked  = blank_lz && (idx > top_nz);
    an_next  = '1;
    seg_next = SEG_BLANK;
    if (!blanked) begin
      an_next[idx] = 1'b0;
      seg_next     = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (scan_en) begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with DIGITS=4, DATA_W=32, REFRESH_DIV=4.
module tb_ssd_scan_ctrl;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        load;
  logic [0:0]  page;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_sync;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 0;

  // Model state: edge count since reset release, shadow and shown values.
  int          n         = 0;
  logic [31:0] m_shadow  = '0;
  logic        m_spage   = 1'b0;
  logic [31:0] m_disp    = '0;
  logic        m_dpage   = 1'b0;
  logic        m_pend    = 1'b0;
  logic [3:0]  exp_an    = 4'hF;
  logic [6:0]  exp_seg   = 7'h7F;
  logic        exp_seg_v = 1'b1;
  logic        exp_fs    = 1'b0;

  ssd_scan_ctrl #(
    .DIGITS      (4),
    .DATA_W      (32),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .page       (page),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .frame_sync (frame_sync)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What digit d of value v on page pg must look like.
  function automatic void model_digit(input logic [31:0] v, input logic pg, input int d,
                                      input logic blz, output logic [3:0] a,
                                      output logic [6:0] s, output logic sv);
    logic [15:0] win;
    logic [3:0]  nib;
    int          hi;
    win = pg ? v[31:16] : v[15:0];
    hi  = 0;
    for (int i = 0; i < 4; i++) begin
      if (win[i*4 +: 4] != 4'h0) hi = i;
    end
    nib = win[d*4 +: 4];
    if (blz && d > hi) begin
      a  = 4'hF;
      s  = 7'h7F;
      sv = 1'b0;
    end else begin
      a    = 4'hF;
      a[d] = 1'b0;
      s    = HEX_TAB[nib];
      sv   = 1'b1;
    end
  endfunction

  // Model: a digit slot lasts 4 edges, a frame 16; the first lit output follows
  // edge 5 and the frame boundary falls on edges 4, 20, 36, ...
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        n = 0; m_shadow = '0; m_spage = 1'b0; m_disp = '0; m_dpage = 1'b0; m_pend = 1'b0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_seg_v = 1'b1; exp_fs = 1'b0;
      end else begin
        n++;
        if (n >= 5) begin
          model_digit(m_disp, m_dpage, ((n - 5) / 4) % 4, blank_lz, exp_an, exp_seg, exp_seg_v);
        end
        exp_fs = (n % 16 == 4) && m_pend;
        if (exp_fs) begin
          m_disp  = m_shadow;
          m_dpage = m_spage;
          m_pend  = 1'b0;
        end
        if (load) begin
          m_shadow = data_in;
          m_spage  = page[0];
          m_pend   = 1'b1;
        end
      end
    end
  end

  // Scoreboard compare on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("an", {28'h0, an}, {28'h0, exp_an});
        if (exp_seg_v) chk("seg", {25'h0, seg}, {25'h0, exp_seg});
        chk("frame_sync", {31'h0, frame_sync}, {31'h0, exp_fs});
        chk("an_onehot", {31'h0, ($countones(~an) <= 1)}, 32'h1);
      end
    end
  end

  // Driver tasks
  task automatic do_load(input logic [31:0] v, input logic pg);
    @(negedge clk);
    data_in = v;
    page    = pg;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (frame_sync) seen = 1;
    end
    chk(name, {31'h0, seen}, 32'h1);
  endtask

  task automatic check_digit(input int d, input logic [6:0] s, input string name);
    bit   found = 0;
    logic [3:0] want;
    want    = 4'hF;
    want[d] = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an == want) found = 1;
    end
    if (!found) chk({name, "_timeout"}, 32'h0, 32'h1);
    else        chk(name, {25'h0, seg}, {25'h0, s});
  endtask

  task automatic check_restart(input string name);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({name, "_blank_an"}, {28'h0, an}, 32'hF);
      chk({name, "_blank_seg"}, {25'h0, seg}, 32'h7F);
    end
    @(negedge clk);
    chk({name, "_first_an"}, {28'h0, an}, 32'hE);
    chk({name, "_first_seg"}, {25'h0, seg}, 32'h40);
  endtask

  int viol;
  int fs_cnt;

  initial begin
    reset = 1'b1; load = 1'b0; data_in = '0; page = '0; blank_lz = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    cmp_on = 1;
    chk("reset_an", {28'h0, an}, 32'hF);
    chk("reset_seg", {25'h0, seg}, 32'h7F);
    reset = 1'b1;

    // Blank until the first tick, then digit 0 shows '0'.
    check_restart("release");

    // Page 0 of 0x1234ABCD: D C B A.
    do_load(32'h1234ABCD, 1'b0);
    wait_fs("fs_load0");
    check_digit(0, 7'h21, "p0_d0");
    check_digit(1, 7'h46, "p0_d1");
    check_digit(2, 7'h03, "p0_d2");
    check_digit(3, 7'h08, "p0_d3");

    // Page 1 loaded mid-frame: old digits persist until the boundary.
    check_digit(1, 7'h46, "p1_pre_d1");
    do_load(32'h1234ABCD, 1'b1);
    check_digit(2, 7'h03, "p1_hold_d2");
    wait_fs("fs_load1");
    check_digit(0, 7'h19, "p1_d0");
    check_digit(3, 7'h79, "p1_d3");

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(32'h00000012, 1'b0);
    wait_fs("fs_lz12");
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an[3] == 1'b0 || an[2] == 1'b0) viol++;
    end
    chk("lz12_upper_dark", viol, 0);
    check_digit(1, 7'h79, "lz12_d1");
    check_digit(0, 7'h24, "lz12_d0");

    do_load(32'h00000000, 1'b0);
    wait_fs("fs_lz0");
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an != 4'hE && an != 4'hF) viol++;
    end
    chk("lz0_only_d0", viol, 0);
    check_digit(0, 7'h40, "lz0_d0");

    // Two loads in one frame: only the second shows, one frame_sync.
    blank_lz = 1'b0;
    do_load(32'h0000BEEF, 1'b0);
    repeat (2) @(negedge clk);
    do_load(32'h0000CAFE, 1'b0);
    fs_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_sync) fs_cnt++;
    end
    chk("double_load_fs_count", fs_cnt, 1);
    check_digit(0, 7'h06, "dbl_d0");
    check_digit(1, 7'h0E, "dbl_d1");
    check_digit(2, 7'h08, "dbl_d2");
    check_digit(3, 7'h46, "dbl_d3");

    // Asynchronous reset mid-scan discards a pending load.
    repeat (4) @(negedge clk);
    do_load(32'h55555555, 1'b0);
    @(posedge clk);
    #2;
    chk("lit_before_reset", {31'h0, (an != 4'hF)}, 32'h1);
    reset = 1'b0;
    #1;
    chk("async_reset_an", {28'h0, an}, 32'hF);
    chk("async_reset_seg", {25'h0, seg}, 32'h7F);
    chk("async_reset_fs", {31'h0, frame_sync}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_restart("rerelease");
    fs_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_sync) fs_cnt++;
    end
    chk("discarded_load_no_fs", fs_cnt, 0);

    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
